// File: rtl/key_pkg.sv
// Shared constants and state encoding for the key press classifier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package key_pkg;

    // Counter widths: debounce window and hold/repeat timers
    localparam int DEB_W = 20;
    localparam int CNT_W = 26;

    // Default terminal counts for a 50 MHz clock
    localparam logic [DEB_W-1:0] T_DEB_DEF  = 20'd499_999;     // 10 ms
    localparam logic [CNT_W-1:0] T_LONG_DEF = 26'd49_999_999;  // 1 s
    localparam logic [CNT_W-1:0] T_REP_DEF  = 26'd9_999_999;   // 200 ms

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEB_DOWN = 2'd1,
        HELD     = 2'd2,
        DEB_UP   = 2'd3
    } key_state_e;

endpackage

// File: rtl/key_press_ctrl_if.sv
// Bundle of edge-detector inputs, raw key level and classified event outputs.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are single-cycle pulses or levels.
interface key_press_ctrl_if;

    logic H2L_Sig;     // falling-edge pulse from the edge detector
    logic L2H_Sig;     // rising-edge pulse from the edge detector
    logic Pin_In;      // raw, asynchronous key level (pressed = 0)
    logic Short_Sig;   // short press confirmed
    logic Long_Sig;    // hold reached the long threshold
    logic Repeat_Sig;  // auto-repeat tick after a long press
    logic Busy;        // classifier is not idle

    // master drives the key side and consumes events
    modport master (
        output H2L_Sig, L2H_Sig, Pin_In,
        input  Short_Sig, Long_Sig, Repeat_Sig, Busy
    );

    // slave is the classifier itself
    modport slave (
        input  H2L_Sig, L2H_Sig, Pin_In,
        output Short_Sig, Long_Sig, Repeat_Sig, Busy
    );

endinterface

// File: rtl/key_press_ctrl_sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit, reset value selectable.
// Latency: 2 cycles from d_i to q_o.
// Backpressure: none.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous input through two flops
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_press_ctrl.sv
// Key press classifier: debounces press/release, emits short/long/repeat pulses.
// Latency: events registered one cycle after the deciding counter compare.
// Backpressure: none; outputs are fire-and-forget one-cycle pulses.
module key_press_ctrl
    import key_pkg::*;
#(
    parameter logic [DEB_W-1:0] T_DEB  = T_DEB_DEF,
    parameter logic [CNT_W-1:0] T_LONG = T_LONG_DEF,
    parameter logic [CNT_W-1:0] T_REP  = T_REP_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    key_press_ctrl_if.slave  kif
);

    key_state_e        state_q, state_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic              long_flag_q, long_flag_d;
    logic              short_q, short_d;
    logic              long_q, long_d;
    logic              rep_q, rep_d;
    logic              busy_q, busy_d;

    logic              pin_s;
    logic              deb_done;
    logic              release_ok;
    logic              timing_on;

    // Key idles high, so the synchroniser resets to "released"
    sync_2ff #(.RST_VAL(1'b1)) u_pin_sync (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (kif.Pin_In),
        .q_o   (pin_s)
    );

    assign deb_done   = (deb_cnt_q == T_DEB);
    // A confirmed release outranks a long threshold landing on the same cycle
    assign release_ok = (state_q == DEB_UP) && deb_done && pin_s;
    // Hold and repeat timers keep running through release debounce
    assign timing_on  = (state_q == HELD) || (state_q == DEB_UP);

    // Next-state, counter and event logic
    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        long_flag_d = long_flag_q;
        short_d     = 1'b0;
        long_d      = 1'b0;
        rep_d       = 1'b0;

        if (timing_on) begin
            if (hold_cnt_q < T_LONG) begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
            if ((hold_cnt_q == T_LONG) && !long_flag_q && !release_ok) begin
                long_d      = 1'b1;
                long_flag_d = 1'b1;
                rep_cnt_d   = '0;
            end else if (long_flag_q) begin
                if (rep_cnt_q == T_REP) begin
                    rep_d     = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + CNT_W'(1);
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (kif.H2L_Sig) begin
                    state_d   = DEB_DOWN;
                    deb_cnt_d = '0;
                end
            end
            DEB_DOWN: begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
                if (deb_done) begin
                    deb_cnt_d = '0;
                    if (!pin_s) begin
                        state_d     = HELD;
                        hold_cnt_d  = '0;
                        rep_cnt_d   = '0;
                        long_flag_d = 1'b0;
                    end else begin
                        // level bounced back: a glitch, drop it silently
                        state_d = IDLE;
                    end
                end
            end
            HELD: begin
                if (kif.L2H_Sig) begin
                    state_d   = DEB_UP;
                    deb_cnt_d = '0;
                end
            end
            DEB_UP: begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
                if (deb_done) begin
                    deb_cnt_d = '0;
                    if (pin_s) begin
                        short_d     = !long_flag_q;
                        long_flag_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        // release bounce: resume the hold without restarting timers
                        state_d = HELD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, counters and registered event outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            rep_cnt_q   <= '0;
            long_flag_q <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            rep_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            long_flag_q <= long_flag_d;
            short_q     <= short_d;
            long_q      <= long_d;
            rep_q       <= rep_d;
            busy_q      <= busy_d;
        end
    end

    assign kif.Short_Sig  = short_q;
    assign kif.Long_Sig   = long_q;
    assign kif.Repeat_Sig = rep_q;
    assign kif.Busy       = busy_q;

endmodule

// File: doc/key_press_ctrl.md
# key_press_ctrl

Press-classification controller that sits directly after the key edge detector. It consumes the detector's one-cycle H2L_Sig/L2H_Sig pulses plus the raw key level. It sequences debounce windows, confirms press and release, and times the hold. It emits one-cycle Short_Sig, Long_Sig and Repeat_Sig events to application logic such as LED or menu control. The key is active-low: pressed = 0.

## Interface
- T_DEB, 20'd499_999, debounce window terminal count (10 ms at 50 MHz)
- T_LONG, 26'd49_999_999, hold terminal count for long press (1 s)
- T_REP, 26'd9_999_999, auto-repeat period terminal count after long press (200 ms)
- CLK  input  1  system clock, 50 MHz
- RST  input  1  reset, asynchronous, active-high
- H2L_Sig  input  1  one-cycle pulse from the edge detector on a falling edge
- L2H_Sig  input  1  one-cycle pulse from the edge detector on a rising edge
- Pin_In  input  1  raw key level, asynchronous; synchronised internally by two flops into pin_s
- Short_Sig  output  1  one-cycle pulse: confirmed release before the long threshold
- Long_Sig  output  1  one-cycle pulse: hold reached T_LONG
- Repeat_Sig  output  1  one-cycle pulse every T_REP+1 cycles while held after Long_Sig
- Busy  output  1  high whenever state != IDLE

## Operation
- States: IDLE, DEB_DOWN, HELD, DEB_UP.
- IDLE: when H2L_Sig=1, go to DEB_DOWN and clear deb_cnt. L2H_Sig is ignored.
- DEB_DOWN: deb_cnt increments each cycle and all edge pulses are ignored. On the cycle where deb_cnt==T_DEB:
  - pin_s==0: go to HELD; clear hold_cnt, rep_cnt and long_flag.
  - pin_s==1: go to IDLE. This is a rejected glitch and produces no output.
- HELD: hold_cnt increments and saturates at T_LONG.
  - When hold_cnt==T_LONG and long_flag==0: pulse Long_Sig, set long_flag, clear rep_cnt.
  - While long_flag==1: rep_cnt increments. At rep_cnt==T_REP, pulse Repeat_Sig and wrap rep_cnt to 0.
  - When L2H_Sig=1: go to DEB_UP and clear deb_cnt.
- DEB_UP: deb_cnt increments. hold_cnt and rep_cnt keep running, and Long_Sig/Repeat_Sig may still fire here. H2L_Sig is ignored. On the cycle where deb_cnt==T_DEB:
  - pin_s==1: release is confirmed. Pulse Short_Sig only if long_flag==0, clear long_flag, go to IDLE.
  - pin_s==0: go back to HELD. This was release bounce; hold_cnt and rep_cnt are not cleared.
- Simultaneous events:
  - L2H_Sig in the same cycle as the long threshold or a repeat tick: the pulse is still emitted, and the transition to DEB_UP also occurs.
  - Long threshold in the same cycle as DEB_UP confirming release: the release wins. No Long_Sig, and Short_Sig fires.
- At most one of Short_Sig, Long_Sig, Repeat_Sig is high in any cycle, except that Long_Sig and Repeat_Sig never coincide because rep_cnt restarts at Long_Sig.
- Exactly one of Short_Sig or Long_Sig fires per confirmed press.
- Counter widths: deb_cnt 20 bits, hold_cnt and rep_cnt 26 bits. There is no overflow: hold_cnt saturates, rep_cnt wraps by compare.

## Timing
- RST asserted:
  - state=IDLE; all counters and long_flag = 0.
  - Short_Sig=0, Long_Sig=0, Repeat_Sig=0, Busy=0.
  - The pin_s synchroniser flops reset to 1 (released).
- RST asserted mid-operation aborts immediately and emits no pulse. After release, the block waits for a fresh H2L_Sig.
- All outputs are registered and high for exactly one CLK cycle.
- H2L_Sig sampled at edge k:
  - Busy=1 from k+1.
  - The debounce decision is made at edge k+1+T_DEB.
  - HELD is entered at edge k+2+T_DEB.
- Long_Sig rises T_LONG+1 cycles after HELD is entered.
- Each subsequent Repeat_Sig rises T_REP+1 cycles after the previous Long_Sig or Repeat_Sig.
- Short_Sig and Busy=0 appear at the same edge, one cycle after the DEB_UP decision.
- Pin_In to pin_s latency is 2 cycles. This is covered by the window because the edge detector also delays the edge.

## Structure
- Package key_pkg holds:
  - the state enum/localparams (IDLE=2'd0, DEB_DOWN=2'd1, HELD=2'd2, DEB_UP=2'd3);
  - the default T_DEB, T_LONG and T_REP constants;
  - the counter width constants.
- One sub-module, sync_2ff (1-bit, reset value parameterised), for Pin_In.
- Everything else is a single FSM plus counters in key_press_ctrl.

## Test plan
Bench uses T_DEB=9, T_LONG=99, T_REP=19.
- Clean press of 50 cycles, then release. Required: Busy high, one Short_Sig about 11 cycles after L2H_Sig, no Long_Sig.
- Glitch: H2L_Sig with Pin_In back to 1 after 3 cycles. Required: debounce rejects it, Busy drops after 11 cycles, no outputs.
- Hold for 160 cycles. Required: Long_Sig 100 cycles after HELD entry, Repeat_Sig at +20 and +40, no Short_Sig after release.
- Release bounce: in HELD, L2H_Sig with Pin_In returning to 0 within 5 cycles. Required: back to HELD, hold_cnt uninterrupted, Long_Sig still at 100.
- RST pulsed at hold_cnt=60. Required: all outputs 0 and Busy=0 immediately. A following clean press gives a normal Short_Sig.
- L2H_Sig on the same cycle hold_cnt reaches T_LONG. Required: Long_Sig fires and DEB_UP is entered. After the confirmed release, no Short_Sig.
